uart_rx_frontend: RTL and testbench

- Receive front end of the UART path, directly upstream of rx_fifo.
- Synchronizes the asynchronous serial line, detects a start bit and samples each bit at its midpoint.
- Assembles an 8N1 frame LSB-first, then writes the byte into rx_fifo through its w_enable/w_data write port.
- Reports sticky framing and overrun errors.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_rx_frontend_if.sv | 12 +
 rtl/uart_rx_frontend_bit_timer.sv | 45 ++++
 rtl/uart_rx_frontend.sv | 160 ++++++++++++++++
 tb/tb_uart_rx_frontend.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive path.
// Latency: n/a. Backpressure: n/a.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        LOAD
    } rx_state_t;

    localparam int CLKS_PER_BIT_DEF = 10;
    localparam int DATA_BITS_DEF    = 8;

endpackage

// File: rtl/uart_rx_frontend_if.sv
// Write port into rx_fifo: byte strobe/data out, full flag back.
// Latency: n/a. Backpressure: fifo_full only; there is no stall, the writer drops.
interface uart_rx_frontend_if #(
    parameter int DATA_BITS = uart_pkg::DATA_BITS_DEF
) ();
    logic                 w_enable;
    logic [DATA_BITS-1:0] w_data;
    logic                 fifo_full;

    modport master (output w_enable, output w_data, input fifo_full);
    modport slave  (input w_enable, input w_data, output fifo_full);
endinterface

// File: rtl/uart_rx_frontend_bit_timer.sv
// Bit-period counter with half/full terminal ticks plus a data-bit index counter.
// Latency: ticks are combinational from the registered count. Backpressure: none.
module bit_timer #(
    parameter int CLKS_PER_BIT = 10,
    parameter int DATA_BITS    = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    input  logic i_idx_clr,
    input  logic i_idx_inc,
    output logic o_half_tick,
    output logic o_full_tick,
    output logic o_last_bit
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] HALF_TC = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_TC = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_IX = IW'(DATA_BITS - 1);

    logic [CW-1:0] r_count;
    logic [IW-1:0] r_idx;

    assign o_half_tick = (r_count == HALF_TC);
    assign o_full_tick = (r_count == FULL_TC);
    assign o_last_bit  = (r_idx == LAST_IX);

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            r_count <= o_full_tick ? '0 : r_count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || i_idx_clr) begin
            r_idx <= '0;
        end else if (i_idx_inc) begin
            r_idx <= r_idx + 1'b1;
        end
    end
endmodule

// File: rtl/uart_rx_frontend.sv
// 8N1 UART receiver: synchronise line, mid-bit sample, write byte into rx_fifo, sticky errors.
// Latency: write strobe CLKS_PER_BIT/2 + (DATA_BITS+1)*CLKS_PER_BIT + 1 cycles after start detect.
// Backpressure: none; a good byte arriving with fifo_full=1 is dropped and flags overrun.
module uart_rx_frontend
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int DATA_BITS    = DATA_BITS_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                serial_in,
    input  logic                clear_errors,
    uart_rx_frontend_if.master  fifo_if,
    output logic                framing_error,
    output logic                overrun_error,
    output logic                busy
);
    logic                 r_sync1, r_sync2, r_hist;
    rx_state_t            r_state, w_next;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_stop_bit;
    logic                 r_wen;
    logic [DATA_BITS-1:0] r_wdata;
    logic                 r_framing, r_overrun;

    logic w_start_edge;
    logic w_tmr_clr, w_tmr_en, w_idx_clr, w_idx_inc;
    logic w_sample_data, w_sample_stop;
    logic w_half_tick, w_full_tick, w_last_bit;
    logic w_load_good, w_load_ovr, w_load_frm;

    bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .DATA_BITS    (DATA_BITS)
    ) u_bit_timer (
        .clk         (clk),
        .rst         (rst),
        .i_clr       (w_tmr_clr),
        .i_en        (w_tmr_en),
        .i_idx_clr   (w_idx_clr),
        .i_idx_inc   (w_idx_inc),
        .o_half_tick (w_half_tick),
        .o_full_tick (w_full_tick),
        .o_last_bit  (w_last_bit)
    );

    // Only a fresh 1->0 transition starts a frame, so a held-low break never re-arms.
    assign w_start_edge = r_hist & ~r_sync2;

    always_comb begin
        w_next        = r_state;
        w_tmr_clr     = 1'b0;
        w_tmr_en      = 1'b0;
        w_idx_clr     = 1'b0;
        w_idx_inc     = 1'b0;
        w_sample_data = 1'b0;
        w_sample_stop = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start_edge) begin
                    w_next    = START;
                    w_tmr_clr = 1'b1;
                end
            end
            START: begin
                w_tmr_en = 1'b1;
                if (w_half_tick) begin
                    w_tmr_clr = 1'b1;
                    w_idx_clr = 1'b1;
                    w_next    = r_sync2 ? IDLE : DATA;
                end
            end
            DATA: begin
                w_tmr_en = 1'b1;
                if (w_full_tick) begin
                    w_sample_data = 1'b1;
                    w_idx_inc     = 1'b1;
                    if (w_last_bit) begin
                        w_next = STOP;
                    end
                end
            end
            STOP: begin
                w_tmr_en = 1'b1;
                if (w_full_tick) begin
                    w_sample_stop = 1'b1;
                    w_next        = LOAD;
                end
            end
            LOAD: begin
                // A start edge may already be visible here on back-to-back traffic.
                if (w_start_edge) begin
                    w_next    = START;
                    w_tmr_clr = 1'b1;
                end else begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    assign w_load_good = (r_state == LOAD) &&  r_stop_bit && !fifo_if.fifo_full;
    assign w_load_ovr  = (r_state == LOAD) &&  r_stop_bit &&  fifo_if.fifo_full;
    assign w_load_frm  = (r_state == LOAD) && !r_stop_bit;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_hist     <= 1'b1;
            r_state    <= IDLE;
            r_shift    <= '0;
            r_stop_bit <= 1'b0;
        end else begin
            r_sync1 <= serial_in;
            r_sync2 <= r_sync1;
            r_hist  <= r_sync2;
            r_state <= w_next;
            if (w_sample_data) begin
                r_shift <= {r_sync2, r_shift[DATA_BITS-1:1]};
            end
            if (w_sample_stop) begin
                r_stop_bit <= r_sync2;
            end
        end
    end

    // Error set takes priority over a coincident clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wen     <= 1'b0;
            r_wdata   <= '0;
            r_framing <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_wen <= w_load_good;
            if (w_load_good) begin
                r_wdata <= r_shift;
            end
            if (w_load_frm) begin
                r_framing <= 1'b1;
            end else if (clear_errors) begin
                r_framing <= 1'b0;
            end
            if (w_load_ovr) begin
                r_overrun <= 1'b1;
            end else if (clear_errors) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign fifo_if.w_enable = r_wen;
    assign fifo_if.w_data   = r_wdata;
    assign framing_error    = r_framing;
    assign overrun_error    = r_overrun;
    assign busy             = (r_state != IDLE);
endmodule

// File: tb/tb_uart_rx_frontend.sv
// Scoreboarded bench for uart_rx_frontend: directed frames then randomized traffic.
module tb_uart_rx_frontend;
    import uart_pkg::*;

    localparam int CPB = 10;
    localparam int DB  = 8;
    // Start bit driven just after edge e: write strobe visible after edge e + 3 + CPB/2 + 9*CPB + 1.
    localparam int WR_OFS = 3 + CPB / 2 + (DB + 1) * CPB + 1;

    logic clk = 1'b0;
    logic rst, serial_in, clear_errors;
    logic framing_error, overrun_error, busy;

    uart_rx_frontend_if #(.DATA_BITS(DB)) fifo_if ();

    uart_rx_frontend #(
        .CLKS_PER_BIT (CPB),
        .DATA_BITS    (DB)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .serial_in     (serial_in),
        .clear_errors  (clear_errors),
        .fifo_if       (fifo_if.master),
        .framing_error (framing_error),
        .overrun_error (overrun_error),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0]  data;
        int unsigned at;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    bit   exp_fe = 1'b0;
    bit   exp_ov = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t x;
        if (fifo_if.w_enable === 1'b1) begin
            if (sbq.size() == 0) begin
                check("unexpected_write", 32'd1, 32'd0);
            end else begin
                x = sbq.pop_front();
                check("w_data", {24'd0, fifo_if.w_data}, {24'd0, x.data});
                check("write_cycle", cyc, x.at);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_flags(input string tag);
        check({tag, "_framing"}, {31'd0, framing_error}, {31'd0, exp_fe});
        check({tag, "_overrun"}, {31'd0, overrun_error}, {31'd0, exp_ov});
    endtask

    // Called #1 after a clock edge; returns #1 after the edge ending the stop bit.
    task automatic send_frame(input logic [7:0] d, input bit stop, input bit full, input bit clr_at_load);
        int unsigned e;
        logic [9:0]  bits;
        e = cyc;
        bits = {stop, d, 1'b0};
        fifo_if.fifo_full = full;
        if (stop && !full) sbq.push_back('{data: d, at: e + WR_OFS});
        for (int k = 0; k < 10 * CPB; k++) begin
            serial_in    = bits[k / CPB];
            clear_errors = clr_at_load && (k == WR_OFS - 1);
            if (k == 5 * CPB) check("busy_mid_frame", {31'd0, busy}, 32'd1);
            @(posedge clk);
            #1;
        end
        serial_in         = 1'b1;
        clear_errors      = 1'b0;
        fifo_if.fifo_full = 1'b0;
        if (clr_at_load) begin
            exp_fe = 1'b0;
            exp_ov = 1'b0;
        end
        if (!stop) exp_fe = 1'b1;
        else if (full) exp_ov = 1'b1;
        check_flags("frame_end");
        check("pending_writes", sbq.size(), 32'd0);
    endtask

    task automatic pulse_clear();
        clear_errors = 1'b1;
        @(posedge clk);
        #1;
        clear_errors = 1'b0;
        exp_fe = 1'b0;
        exp_ov = 1'b0;
        check_flags("after_clear");
    endtask

    task automatic send_glitch();
        serial_in = 1'b0;
        idle(3);
        check("glitch_busy", {31'd0, busy}, 32'd1);
        serial_in = 1'b1;
        idle(6);
        check("glitch_idle", {31'd0, busy}, 32'd0);
        check_flags("glitch");
    endtask

    // Reset lands inside data bit 4; the transmitter abandons the frame.
    task automatic send_abort(input logic [7:0] d);
        logic [9:0] bits;
        bits = {1'b1, d, 1'b0};
        for (int k = 0; k < 5 * CPB + CPB / 2; k++) begin
            serial_in = bits[k / CPB];
            @(posedge clk);
            #1;
        end
        rst       = 1'b1;
        serial_in = 1'b1;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        exp_fe = 1'b0;
        exp_ov = 1'b0;
        check("abort_w_enable", {31'd0, fifo_if.w_enable}, 32'd0);
        check("abort_w_data", {24'd0, fifo_if.w_data}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check_flags("abort");
        idle(2 * CPB);
        check("abort_stays_idle", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        bit          prev_bad;
        logic [7:0]  rd;
        bit          rstop, rfull, rclr;
        int          gap;

        rst               = 1'b1;
        serial_in         = 1'b1;
        clear_errors      = 1'b0;
        fifo_if.fifo_full = 1'b0;
        idle(3);
        check("reset_w_enable", {31'd0, fifo_if.w_enable}, 32'd0);
        check("reset_w_data", {24'd0, fifo_if.w_data}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check_flags("reset");
        rst = 1'b0;
        idle(5);

        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        idle(3);
        check("post_frame_busy", {31'd0, busy}, 32'd0);

        send_glitch();
        idle(4);

        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        idle(8);
        check_flags("framing_sticky");
        pulse_clear();
        idle(4);

        send_frame(8'h5A, 1'b1, 1'b1, 1'b0);
        send_frame(8'h11, 1'b1, 1'b0, 1'b0);
        idle(3);
        pulse_clear();
        idle(3);

        send_frame(8'h00, 1'b1, 1'b0, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
        idle(3);

        send_frame(8'h3C, 1'b0, 1'b0, 1'b1);
        idle(3);
        pulse_clear();
        idle(3);

        send_abort(8'h81);
        send_frame(8'h7E, 1'b1, 1'b0, 1'b0);
        idle(3);

        prev_bad = 1'b0;
        for (int i = 0; i < 24; i++) begin
            rd    = 8'($urandom);
            rstop = ($urandom % 5) != 0;
            rfull = ($urandom % 4) == 0;
            rclr  = ($urandom % 6) == 0;
            gap   = prev_bad ? 2 + int'($urandom % 3) : int'($urandom % 4);
            idle(gap);
            send_frame(rd, rstop, rfull, rclr);
            prev_bad = !rstop;
        end

        idle(2 * CPB);
        check("final_pending", sbq.size(), 32'd0);
        check("final_busy", {31'd0, busy}, 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
